battleship_shot_controller: RTL

- Sequencing FSM for one player's turn in the Battleship board design.
- Takes raw switch/key input (X, Y, big-bomb select, score key) and validates the shot.
- Issues one or more cell lookups to the ship-map block over a req/ack handshake, then scores the result.
- Outputs drive the LEDR hit/near-miss/miss banks, the LEDG biggest-ship bits, the HEX0 hit digit and the HEX6/HEX7 something-wrong indicator.

---
 rtl/battleship_shot_controller.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/battleship_shot_controller.sv
// battleship_shot_controller: sequences one player's shot in the Battleship game.
// The fire key is synchronised and edge-detected. Each accepted press is
// validated, then looked up cell by cell over a req/ack handshake with the
// ship map, and finally scored into the LED/HEX outputs.
//
// Optional build macro SHOT_LIMIT_EN adds a per-game shot budget
// (parameter MAX_SHOTS, outputs shots_left and out_of_shots).
//
// state    | meaning
// IDLE     | waiting for an accepted fire press
// VALIDATE | range / big-bomb check, loads the cell list
// LOOKUP   | map_req high for the current cell until map_ack
// GAP      | one-cycle request gap between consecutive cells
// SCORE    | publish result flags and update hit_count / game_over
module battleship_shot_controller #(
  parameter int BIG_BOMBS   = 2,
  parameter int HITS_TO_WIN = 9,
  parameter int NUM_SHIPS   = 5
`ifdef SHOT_LIMIT_EN
  ,parameter int MAX_SHOTS  = 20
`endif
) (
  input  logic                 clock,
  input  logic                 reset_L,
  input  logic [3:0]           x,
  input  logic [3:0]           y,
  input  logic                 big,
  input  logic                 score_L,
  output logic                 map_req,
  output logic [3:0]           map_x,
  output logic [3:0]           map_y,
  input  logic                 map_ack,
  input  logic                 map_hit,
  input  logic                 map_near,
  input  logic [NUM_SHIPS-1:0] map_ship,
  output logic                 hit,
  output logic                 near_miss,
  output logic                 miss,
  output logic                 wrong,
  output logic [3:0]           hit_count,
  output logic [1:0]           big_left,
  output logic [NUM_SHIPS-1:0] ships_hit,
  output logic                 busy,
  output logic                 game_over
`ifdef SHOT_LIMIT_EN
  ,output logic [4:0]          shots_left,
  output logic                 out_of_shots
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_VALIDATE, S_LOOKUP, S_GAP, S_SCORE} state_t;

  state_t      state, state_nx;
  logic        key_s1, key_s2, key_d;
  logic        press, accept, stop;
  logic [3:0]  shot_x, shot_y;
  logic        shot_big, shot_ok;
  logic [4:0]  cell_mask, cur_cell, rest_mask;
  logic [3:0]  cell_x, cell_y;
  logic        any_hit, any_near;
  logic [2:0]  pending;
  logic [4:0]  score_sum;
  logic [3:0]  score_total;
  logic        win;

  function automatic logic in_range(input logic [3:0] v);
    return (v >= 4'd1) && (v <= 4'd10);
  endfunction

`ifdef SHOT_LIMIT_EN
  assign stop = game_over | out_of_shots;
`else
  assign stop = game_over;
`endif

  assign press   = key_d & ~key_s2;
  assign accept  = press && (state == S_IDLE) && !stop;
  assign shot_ok = in_range(shot_x) && in_range(shot_y) && !(shot_big && (big_left == 2'd0));

  // Lowest pending cell is served first, which gives centre, left, right, up, down order.
  assign cur_cell  = cell_mask & (~cell_mask + 5'd1);
  assign rest_mask = cell_mask & ~cur_cell;

  assign score_sum   = {1'b0, hit_count} + {2'b00, pending};
  assign score_total = (score_sum > 5'd9) ? 4'd9 : score_sum[3:0];
  assign win         = score_total >= 4'(HITS_TO_WIN);

  // Two-flop synchroniser plus edge-detect history for the raw key.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      key_d  <= 1'b1;
    end else begin
      key_s1 <= score_L;
      key_s2 <= key_s1;
      key_d  <= key_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= S_IDLE;
    else          state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:     if (accept) state_nx = S_VALIDATE;
      S_VALIDATE: state_nx = shot_ok ? S_LOOKUP : S_IDLE;
      S_LOOKUP:   if (map_ack) state_nx = (rest_mask == 5'd0) ? S_SCORE : S_GAP;
      S_GAP:      state_nx = S_LOOKUP;
      S_SCORE:    state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Coordinates of the cell currently at the head of the list.
  always_comb begin
    cell_x = shot_x;
    cell_y = shot_y;
    case (cur_cell)
      5'b00010: cell_x = shot_x - 4'd1;
      5'b00100: cell_x = shot_x + 4'd1;
      5'b01000: cell_y = shot_y - 4'd1;
      5'b10000: cell_y = shot_y + 4'd1;
      default:  ;
    endcase
  end

  // FSM outputs; the lookup address is held at zero outside LOOKUP.
  always_comb begin
    map_req = (state == S_LOOKUP);
    busy    = (state != S_IDLE);
    map_x   = map_req ? cell_x : 4'd0;
    map_y   = map_req ? cell_y : 4'd0;
  end

  // Shot registers, lookup accumulators and scoreboard outputs.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      shot_x    <= 4'd0;
      shot_y    <= 4'd0;
      shot_big  <= 1'b0;
      cell_mask <= 5'd0;
      any_hit   <= 1'b0;
      any_near  <= 1'b0;
      pending   <= 3'd0;
      hit       <= 1'b0;
      near_miss <= 1'b0;
      miss      <= 1'b0;
      wrong     <= 1'b0;
      hit_count <= 4'd0;
      big_left  <= 2'(BIG_BOMBS);
      ships_hit <= '0;
      game_over <= 1'b0;
`ifdef SHOT_LIMIT_EN
      shots_left   <= 5'(MAX_SHOTS);
      out_of_shots <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          shot_x    <= x;
          shot_y    <= y;
          shot_big  <= big;
          hit       <= 1'b0;
          near_miss <= 1'b0;
          miss      <= 1'b0;
          wrong     <= 1'b0;
          any_hit   <= 1'b0;
          any_near  <= 1'b0;
          pending   <= 3'd0;
        end
        S_VALIDATE: begin
          if (!shot_ok) begin
            wrong <= 1'b1;
          end else begin
            if (shot_big) big_left <= big_left - 2'd1;
            cell_mask <= shot_big ? {in_range(shot_y + 4'd1), in_range(shot_y - 4'd1),
                                     in_range(shot_x + 4'd1), in_range(shot_x - 4'd1), 1'b1}
                                  : 5'b00001;
          end
        end
        S_LOOKUP: if (map_ack) begin
          any_hit   <= any_hit | map_hit;
          any_near  <= any_near | map_near;
          cell_mask <= rest_mask;
          if (map_hit) begin
            pending   <= pending + 3'd1;
            ships_hit <= ships_hit | map_ship;
          end
        end
        S_SCORE: begin
          hit       <= any_hit;
          near_miss <= !any_hit && any_near;
          miss      <= !any_hit && !any_near;
          hit_count <= score_total;
          if (win) game_over <= 1'b1;
`ifdef SHOT_LIMIT_EN
          // A winning last shot reports the win, not the empty magazine.
          if (shots_left != 5'd0) begin
            shots_left <= shots_left - 5'd1;
            if ((shots_left == 5'd1) && !win) out_of_shots <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
